atmr_vote_monitor: RTL and testbench



---
 rtl/atmr_vote_monitor.sv | 194 +++++++++++++++++++
 tb/tb_atmr_vote_monitor.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/atmr_vote_monitor.sv
// Triple-replica vote monitor: registered bitwise majority with per-replica mismatch
// tracking, masking of a persistently faulty replica, 2-of-2 fallback and sticky failure.

module atmr_rep_track #(
  parameter int CNT_W  = 8,
  parameter int THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_i,
  input  logic             mism_i,
  input  logic             clr_i,
  output logic             hit_o,
  output logic [CNT_W-1:0] err_cnt_o
);
  logic [3:0]       cons_q, cons_d;
  logic [CNT_W-1:0] err_q, err_d;

  always_comb begin
    cons_d = cons_q;
    if (acc_i) begin
      if (!mism_i)               cons_d = 4'd0;
      else if (cons_q != 4'hF)   cons_d = cons_q + 4'd1;
    end
    err_d = err_q;
    if (acc_i && mism_i && !(&err_q)) err_d = err_q + CNT_W'(1);
    // clear has priority over a same-cycle increment
    if (clr_i) err_d = '0;
  end

  // hit reflects the count this accept produces, so the trigger sample itself can mask
  assign hit_o     = acc_i && (cons_d >= 4'(THRESH));
  assign err_cnt_o = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cons_q <= 4'd0;
      err_q  <= '0;
    end else begin
      cons_q <= cons_d;
      err_q  <= err_d;
    end
  end
endmodule

module atmr_vote_monitor #(
  parameter int W      = 8,
  parameter int CNT_W  = 8,
  parameter int THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     rep0,
  input  logic [W-1:0]     rep1,
  input  logic [W-1:0]     rep2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     voted,
  output logic [2:0]       mism,
  output logic [1:0]       state,
  output logic [1:0]       masked_id,
  output logic [CNT_W-1:0] err_cnt0,
  output logic [CNT_W-1:0] err_cnt1,
  output logic [CNT_W-1:0] err_cnt2,
  input  logic             clr_cnt
);
  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_DEGRADED = 2'd1,
    ST_FAIL     = 2'd2
  } st_e;

  st_e                    state_q, state_d;
  logic [1:0]             masked_q, masked_d;
  logic                   out_valid_q, out_valid_d;
  logic [W-1:0]           voted_q, voted_d;
  logic [2:0]             mism_q, mism_d;

  logic                   acc;
  logic [W-1:0]           maj, rep_a, rep_b, rep_m, voted_c;
  logic                   ab_diff;
  logic [2:0]             mism_c, hit;
  logic [2:0][CNT_W-1:0]  err_cnt;

  assign in_ready = !out_valid_q || out_ready;
  assign acc      = in_valid && in_ready;
  assign maj      = (rep0 & rep1) | (rep1 & rep2) | (rep0 & rep2);

  // a/b are the surviving replicas, a the lower index; m is the masked one
  always_comb begin
    rep_a = rep0;
    rep_b = rep1;
    rep_m = rep2;
    case (masked_q)
      2'd0:    begin rep_a = rep1; rep_b = rep2; rep_m = rep0; end
      2'd1:    begin rep_a = rep0; rep_b = rep2; rep_m = rep1; end
      default: begin rep_a = rep0; rep_b = rep1; rep_m = rep2; end
    endcase
  end

  assign ab_diff = (rep_a != rep_b);

  always_comb begin
    voted_c = maj;
    mism_c  = 3'b000;
    case (state_q)
      ST_NORMAL: begin
        voted_c   = maj;
        mism_c[0] = (rep0 != maj);
        mism_c[1] = (rep1 != maj);
        mism_c[2] = (rep2 != maj);
      end
      ST_DEGRADED: begin
        voted_c = rep_a;
        for (int k = 0; k < 3; k++)
          mism_c[k] = (2'(k) == masked_q) ? (rep_m != rep_a) : ab_diff;
      end
      default: begin
        voted_c = rep_a;
        mism_c  = 3'b111;
      end
    endcase
  end

  for (genvar k = 0; k < 3; k++) begin : g_trk
    atmr_rep_track #(.CNT_W(CNT_W), .THRESH(THRESH)) u_trk (
      .clk      (clk),
      .rst      (rst),
      .acc_i    (acc),
      .mism_i   (mism_c[k]),
      .clr_i    (clr_cnt),
      .hit_o    (hit[k]),
      .err_cnt_o(err_cnt[k])
    );
  end

  // Transitions only on accept; the triggering sample was voted under state_q above.
  always_comb begin
    state_d  = state_q;
    masked_d = masked_q;
    if (acc) begin
      case (state_q)
        ST_NORMAL: begin
          if (|hit) begin
            state_d  = ST_DEGRADED;
            masked_d = hit[0] ? 2'd0 : (hit[1] ? 2'd1 : 2'd2);
          end
        end
        ST_DEGRADED: if (ab_diff) state_d = ST_FAIL;
        default: ;
      endcase
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    voted_d     = voted_q;
    mism_d      = mism_q;
    if (acc) begin
      out_valid_d = 1'b1;
      voted_d     = voted_c;
      mism_d      = mism_c;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_NORMAL;
      masked_q    <= 2'd3;
      out_valid_q <= 1'b0;
      voted_q     <= '0;
      mism_q      <= 3'b000;
    end else begin
      state_q     <= state_d;
      masked_q    <= masked_d;
      out_valid_q <= out_valid_d;
      voted_q     <= voted_d;
      mism_q      <= mism_d;
    end
  end

  assign out_valid = out_valid_q;
  assign voted     = voted_q;
  assign mism      = mism_q;
  assign state     = state_q;
  assign masked_id = masked_q;
  assign err_cnt0  = err_cnt[0];
  assign err_cnt1  = err_cnt[1];
  assign err_cnt2  = err_cnt[2];
endmodule

// File: tb/tb_atmr_vote_monitor.sv
// Scoreboard bench for atmr_vote_monitor: a rule-level model predicts each accepted
// sample's vote, a negedge monitor compares DUT outputs against the queued predictions.

module tb_atmr_vote_monitor;
  localparam int W = 8, CNT_W = 8, THRESH = 4;

  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b1, clr_cnt = 1'b0;
  logic [W-1:0] rep0 = '0, rep1 = '0, rep2 = '0;
  logic in_ready, out_valid;
  logic [W-1:0] voted;
  logic [2:0] mism;
  logic [1:0] state, masked_id;
  logic [CNT_W-1:0] err_cnt0, err_cnt1, err_cnt2;

  atmr_vote_monitor #(.W(W), .CNT_W(CNT_W), .THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rep0(rep0), .rep1(rep1), .rep2(rep2), .out_valid(out_valid), .out_ready(out_ready),
    .voted(voted), .mism(mism), .state(state), .masked_id(masked_id),
    .err_cnt0(err_cnt0), .err_cnt1(err_cnt1), .err_cnt2(err_cnt2), .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [W-1:0] v; logic [2:0] mm; } exp_t;
  exp_t q[$];
  int   m_state = 0, m_mask = 3;
  int   m_cons[3] = '{0, 0, 0};
  int   m_err[3]  = '{0, 0, 0};
  bit   m_ov = 0;
  bit   acc;
  exp_t e;

  function automatic void ref_vote(input logic [W-1:0] r[3], input int st, input int msk,
                                   output logic [W-1:0] v, output logic [2:0] mm);
    int u[$];
    if (st == 0) begin
      for (int b = 0; b < W; b++) begin
        int ones = 0;
        for (int k = 0; k < 3; k++) ones += r[k][b];
        v[b] = (ones >= 2);
      end
      for (int k = 0; k < 3; k++) mm[k] = (r[k] != v);
    end else begin
      for (int k = 0; k < 3; k++) if (k != msk) u.push_back(k);
      v = r[u[0]];
      if (st == 2) mm = 3'b111;
      else begin
        mm[msk]  = (r[msk] != v);
        mm[u[0]] = (r[u[0]] != r[u[1]]);
        mm[u[1]] = (r[u[0]] != r[u[1]]);
      end
    end
  endfunction

  function automatic bit pair_differs(input logic [W-1:0] r[3], input int msk);
    int u[$];
    for (int k = 0; k < 3; k++) if (k != msk) u.push_back(k);
    return r[u[0]] != r[u[1]];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_mask = 3; m_ov = 0;
      m_cons = '{0, 0, 0}; m_err = '{0, 0, 0};
      q.delete();
    end else begin
      logic [W-1:0] r[3];
      r = '{rep0, rep1, rep2};
      acc = in_valid && (!m_ov || out_ready);
      if (acc) begin
        ref_vote(r, m_state, m_mask, e.v, e.mm);
        q.push_back(e);
        for (int k = 0; k < 3; k++) begin
          if (e.mm[k]) begin
            m_cons[k] = (m_cons[k] < 15) ? m_cons[k] + 1 : 15;
            m_err[k]  = (m_err[k] < 255) ? m_err[k] + 1 : 255;
          end else m_cons[k] = 0;
        end
        if (m_state == 0) begin
          for (int k = 0; k < 3; k++)
            if (m_state == 0 && m_cons[k] >= THRESH) begin m_state = 1; m_mask = k; end
        end else if (m_state == 1 && pair_differs(r, m_mask)) m_state = 2;
        m_ov = 1;
      end else if (out_ready) m_ov = 0;
      if (clr_cnt) m_err = '{0, 0, 0};
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", out_valid, q.size() != 0);
      chk("in_ready", in_ready, (q.size() == 0) || out_ready);
      if (q.size() != 0) begin
        chk("voted", voted, q[0].v);
        chk("mism", mism, q[0].mm);
        if (out_ready) void'(q.pop_front());
      end
      chk("state", state, m_state);
      chk("masked_id", masked_id, m_mask);
      chk("err_cnt0", err_cnt0, m_err[0]);
      chk("err_cnt1", err_cnt1, m_err[1]);
      chk("err_cnt2", err_cnt2, m_err[2]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] c, input logic ordy, input logic clr);
    in_valid = iv; rep0 = a; rep1 = b; rep2 = c; out_ready = ordy; clr_cnt = clr;
    @(posedge clk); #1;
  endtask

  // async reset mid-cycle: outputs must clear before any clock edge
  task automatic do_rst();
    #3 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_voted", voted, 0);
    chk("rst_mism", mism, 0);
    chk("rst_state", state, 0);
    chk("rst_masked_id", masked_id, 3);
    chk("rst_err", {err_cnt0, err_cnt1, err_cnt2}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk); #1;
    do_rst();
    repeat (3) drv(1, 8'hA5, 8'hA5, 8'hA5, 1, 0);
    repeat (3) drv(1, 8'h3C, 8'h3C, 8'h3D, 1, 0);
    drv(1, 8'h3C, 8'h3C, 8'h3C, 1, 0);
    repeat (4) drv(1, 8'h3C, 8'h3C, 8'h3D, 1, 0);
    drv(1, 8'h12, 8'h12, 8'hFF, 1, 0);
    drv(1, 8'h10, 8'h11, 8'h10, 1, 0);
    repeat (3) drv(1, 8'h22, 8'h22, 8'h22, 1, 0);
    drv(0, 8'h00, 8'h00, 8'h00, 1, 0);
    drv(1, 8'h44, 8'h45, 8'h44, 1, 0);
    do_rst();
    // back-pressure then release
    for (int i = 0; i < 5; i++) drv(1, 8'(8'h50 + i), 8'(8'h50 + i), 8'h01, 0, 0);
    for (int i = 0; i < 5; i++) drv(1, 8'(8'h60 + i), 8'h02, 8'(8'h60 + i), 1, 0);
    drv(0, 8'h00, 8'h00, 8'h00, 1, 0);
    do_rst();
    // mask replica 1, then drive its error counter into saturation
    repeat (4) drv(1, 8'h77, 8'h70, 8'h77, 1, 0);
    repeat (260) drv(1, 8'h77, 8'h70, 8'h77, 1, 0);
    drv(1, 8'h77, 8'h70, 8'h77, 1, 1);
    repeat (2) drv(1, 8'h77, 8'h70, 8'h77, 1, 0);
    // randomized traffic with occasional faults, clears and resets
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] base, r[3];
      if (i % 300 == 299) do_rst();
      base = 8'($urandom);
      for (int k = 0; k < 3; k++)
        r[k] = ($urandom_range(0, 3) == 0) ? base ^ (8'h1 << $urandom_range(0, 7)) : base;
      drv($urandom_range(0, 3) != 0, r[0], r[1], r[2],
          $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    end
    drv(0, 8'h00, 8'h00, 8'h00, 1, 0);
    repeat (2) drv(0, 8'h00, 8'h00, 8'h00, 1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
